// File: rtl/prt_frame_transmitter_if.sv
// Frame transmitter bus bundle: send request, PRT read port, egress byte stream, invalidate, status.
interface prt_frame_transmitter_if #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned MAX_ENTRIES = 16
);
  localparam int unsigned SLOT_W = $clog2(MAX_ENTRIES);

  logic                  req_valid;
  logic                  req_ready;
  logic [SLOT_W-1:0]     req_slot;
  logic [ADDR_WIDTH-1:0] req_len;

  logic                  mem_rd_en;
  logic [SLOT_W-1:0]     mem_rd_slot;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_last;
  logic                  tx_ready;

  logic                  inv_en;
  logic [SLOT_W-1:0]     inv_slot;
  logic                  busy;
  logic [15:0]           frames_sent;

  // Transmitter side
  modport master (
    input  req_valid, req_slot, req_len, mem_rd_data, tx_ready,
    output req_ready, mem_rd_en, mem_rd_slot, mem_rd_addr,
           tx_data, tx_valid, tx_last, inv_en, inv_slot, busy, frames_sent
  );

  // Requester / memory / MAC side
  modport slave (
    output req_valid, req_slot, req_len, mem_rd_data, tx_ready,
    input  req_ready, mem_rd_en, mem_rd_slot, mem_rd_addr,
           tx_data, tx_valid, tx_last, inv_en, inv_slot, busy, frames_sent
  );
endinterface

// File: rtl/prt_frame_transmitter.sv
// Streams one PRT frame out byte-wise, then pulses an invalidate for its slot.
module prt_frame_transmitter #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned MAX_ENTRIES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  prt_frame_transmitter_if.master  bus
);
  localparam int unsigned SLOT_W = $clog2(MAX_ENTRIES);
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_e;

  state_e                state_q, state_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] sent_q, sent_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic [DATA_WIDTH-1:0] fifo_d [2];
  logic                  head_q, head_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [CNT_W-1:0]      frames_q, frames_d;

  logic                  rd_issue;
  logic [1:0]            occ;
  logic                  tx_valid_c;
  logic                  tx_last_c;
  logic                  tx_fire;
  logic                  push;
  logic                  pop;
  logic                  wr_idx;
  logic [DATA_WIDTH-1:0] head_data;

  // Next-state: read issue, fall-through output buffer, frame sequencing
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    len_d    = len_q;
    rd_ptr_d = rd_ptr_q;
    sent_d   = sent_q;
    fifo_d   = fifo_q;
    head_d   = head_q;
    frames_d = frames_q;

    // Returning read data counts as outstanding so the buffer can never overflow.
    occ      = 2'(cnt_q + 2'(rd_vld_q));
    rd_issue = (state_q == STREAM) && (rd_ptr_q < len_q) && (occ < 2'd2);
    rd_vld_d = rd_issue;

    // Data returning this cycle is presented directly when the buffer is empty.
    tx_valid_c = (cnt_q != 2'd0) || rd_vld_q;
    head_data  = (cnt_q != 2'd0) ? fifo_q[head_q] : bus.mem_rd_data;
    tx_last_c  = tx_valid_c && (sent_q == ADDR_WIDTH'(len_q - ADDR_WIDTH'(1)));
    tx_fire    = tx_valid_c && bus.tx_ready;

    push   = rd_vld_q && !((cnt_q == 2'd0) && tx_fire);
    pop    = (cnt_q != 2'd0) && tx_fire;
    wr_idx = head_q ^ cnt_q[0];
    if (push) fifo_d[wr_idx] = bus.mem_rd_data;
    if (pop) head_d = ~head_q;
    cnt_d = 2'(cnt_q + 2'(push) - 2'(pop));

    if (rd_issue) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    if (tx_fire) sent_d = sent_q + ADDR_WIDTH'(1);

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          slot_d   = bus.req_slot;
          len_d    = bus.req_len;
          rd_ptr_d = '0;
          sent_d   = '0;
          state_d  = (bus.req_len != '0) ? STREAM : DONE;
        end
      end
      STREAM: begin
        if (tx_fire && tx_last_c) state_d = DONE;
      end
      DONE: begin
        frames_d = frames_q + CNT_W'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      len_q     <= '0;
      rd_ptr_q  <= '0;
      sent_q    <= '0;
      rd_vld_q  <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      head_q    <= 1'b0;
      cnt_q     <= 2'd0;
      frames_q  <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      len_q     <= len_d;
      rd_ptr_q  <= rd_ptr_d;
      sent_q    <= sent_d;
      rd_vld_q  <= rd_vld_d;
      fifo_q[0] <= fifo_d[0];
      fifo_q[1] <= fifo_d[1];
      head_q    <= head_d;
      cnt_q     <= cnt_d;
      frames_q  <= frames_d;
    end
  end

  // Output decode; slot/address/data are zeroed when their strobe is low
  assign bus.req_ready   = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.mem_rd_en   = rd_issue;
  assign bus.mem_rd_slot = rd_issue ? slot_q : '0;
  assign bus.mem_rd_addr = rd_issue ? rd_ptr_q : '0;
  assign bus.tx_valid    = tx_valid_c;
  assign bus.tx_data     = tx_valid_c ? head_data : '0;
  assign bus.tx_last     = tx_last_c;
  assign bus.inv_en      = (state_q == DONE);
  assign bus.inv_slot    = (state_q == DONE) ? slot_q : '0;
  assign bus.frames_sent = frames_q;

endmodule

// File: tb/tb_prt_frame_transmitter.sv
// Self-checking bench for prt_frame_transmitter: directed scenarios plus randomized frames.
module tb_prt_frame_transmitter;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 10;
  localparam int unsigned ME = 16;
  localparam int unsigned SW = $clog2(ME);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prt_frame_transmitter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_ENTRIES(ME)) bus ();

  prt_frame_transmitter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_ENTRIES(ME)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory contents: byte at (slot, addr) is a fixed function while a frame is in flight
  int mem_base = 0;
  bit mem_mix  = 1'b0;
  function automatic logic [7:0] mem_byte(input logic [SW-1:0] s, input logic [AW-1:0] a);
    return 8'(mem_base + int'(a) + (mem_mix ? int'(s) * 16 : 0));
  endfunction

  // Read port model: data valid exactly one cycle after the strobe, garbage otherwise
  initial begin
    logic          en;
    logic [SW-1:0] s;
    logic [AW-1:0] a;
    bus.mem_rd_data = '0;
    forever begin
      @(negedge clk);
      en = bus.mem_rd_en;
      s  = bus.mem_rd_slot;
      a  = bus.mem_rd_addr;
      @(posedge clk);
      #1;
      bus.mem_rd_data = en ? mem_byte(s, a) : 8'($urandom);
    end
  end

  // Egress ready patterns: 0 always, 1 alternate, 2 random, 3 manual
  int ready_mode   = 0;
  bit manual_ready = 1'b1;
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.tx_ready = 1'b1;
        1:       bus.tx_ready = ~bus.tx_ready;
        2:       bus.tx_ready = 1'($urandom);
        default: bus.tx_ready = manual_ready;
      endcase
    end
  end

  int edges = 0;
  initial forever begin
    @(posedge clk);
    edges++;
  end

  // Reference model / monitor state for the frame currently in flight
  bit          in_frame = 1'b0;
  logic [SW-1:0] cur_slot = '0;
  int cur_len = 0, acc_cyc = 0, rd_next = 0, n_beats = 0, n_stall = 0;
  int last_hs = 0, inv_cyc = 0, n_inv = 0, exp_frames = 0;
  bit tx_seen = 1'b0, ready_chk = 1'b0, stalled = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  always @(negedge clk) begin
    int cyc;
    cyc = edges + 1;
    if (!rst_n) begin
      in_frame   = 1'b0;
      ready_chk  = 1'b0;
      stalled    = 1'b0;
      exp_frames = 0;
    end else begin
      if (ready_chk) begin
        chk("req_ready_after_inv", 32'(bus.req_ready), 32'(1));
        ready_chk = 1'b0;
      end
      if (bus.mem_rd_en) begin
        chk("rd_in_frame", 32'(in_frame), 32'(1));
        chk("rd_slot", 32'(bus.mem_rd_slot), 32'(cur_slot));
        chk("rd_addr", 32'(bus.mem_rd_addr), 32'(rd_next));
        if (rd_next == 0) chk("rd_first_cycle", 32'(cyc), 32'(acc_cyc + 1));
        rd_next++;
        chk("rd_addr_range", 32'(rd_next <= cur_len), 32'(1));
        chk("outstanding_le2", 32'((rd_next - n_beats) <= 2), 32'(1));
      end
      if (bus.tx_valid) begin
        chk("tx_valid_expected", 32'(in_frame && (n_beats < cur_len)), 32'(1));
        if (!tx_seen) begin
          chk("tx_first_cycle", 32'(cyc), 32'(acc_cyc + 2));
          tx_seen = 1'b1;
        end
        if (stalled) begin
          chk("tx_hold_data", 32'(bus.tx_data), 32'(prev_data));
          chk("tx_hold_last", 32'(bus.tx_last), 32'(prev_last));
        end
        if (bus.tx_ready) begin
          chk("tx_data", 32'(bus.tx_data), 32'(mem_byte(cur_slot, AW'(n_beats))));
          chk("tx_last", 32'(bus.tx_last), 32'(n_beats == cur_len - 1));
          n_beats++;
          last_hs = cyc;
          stalled = 1'b0;
        end else begin
          n_stall++;
          stalled   = 1'b1;
          prev_data = bus.tx_data;
          prev_last = bus.tx_last;
        end
      end else begin
        if (stalled) chk("tx_valid_held", 32'(bus.tx_valid), 32'(1));
        stalled = 1'b0;
      end
      if (bus.inv_en) begin
        chk("inv_in_frame", 32'(in_frame), 32'(1));
        chk("inv_slot", 32'(bus.inv_slot), 32'(cur_slot));
        chk("inv_beats", 32'(n_beats), 32'(cur_len));
        chk("inv_reads", 32'(rd_next), 32'(cur_len));
        chk("inv_cycle", 32'(cyc), 32'((cur_len == 0) ? acc_cyc + 1 : last_hs + 1));
        in_frame  = 1'b0;
        inv_cyc   = cyc;
        ready_chk = 1'b1;
        n_inv++;
      end
      if (bus.req_valid && bus.req_ready) begin
        chk("accept_when_idle", 32'(in_frame), 32'(0));
        in_frame = 1'b1;
        cur_slot = bus.req_slot;
        cur_len  = int'(bus.req_len);
        acc_cyc  = cyc;
        rd_next  = 0;
        n_beats  = 0;
        n_stall  = 0;
        tx_seen  = 1'b0;
        stalled  = 1'b0;
        exp_frames++;
      end
    end
  end

  // Present a request and hold it until accepted; returns 1 time unit after the accepting edge
  task automatic send(input logic [SW-1:0] s, input logic [AW-1:0] l);
    bit done = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_slot  = s;
    bus.req_len   = l;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (bus.req_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    bus.req_slot  = SW'($urandom);
    bus.req_len   = AW'($urandom);
    chk("req_accepted", 32'(done), 32'(1));
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      if (!in_frame && !bus.busy) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("idle_reached", 32'(ok), 32'(1));
    chk("frames_sent", 32'(bus.frames_sent), 32'(16'(exp_frames)));
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_ready", 32'(bus.req_ready), 32'(1));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_mem_rd_en", 32'(bus.mem_rd_en), 32'(0));
    chk("rst_mem_rd_slot", 32'(bus.mem_rd_slot), 32'(0));
    chk("rst_mem_rd_addr", 32'(bus.mem_rd_addr), 32'(0));
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'(0));
    chk("rst_tx_data", 32'(bus.tx_data), 32'(0));
    chk("rst_tx_last", 32'(bus.tx_last), 32'(0));
    chk("rst_inv_en", 32'(bus.inv_en), 32'(0));
    chk("rst_inv_slot", 32'(bus.inv_slot), 32'(0));
    chk("rst_frames_sent", 32'(bus.frames_sent), 32'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, inv0, lim;
    logic [SW-1:0] s;
    logic [AW-1:0] l;
    bus.req_valid = 1'b0;
    bus.req_slot  = '0;
    bus.req_len   = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic 4-byte frame at full rate
    mem_base = 'h10; mem_mix = 1'b0; ready_mode = 0;
    send(SW'(3), AW'(4));
    a0 = acc_cyc;
    wait_idle(100);
    chk("t1_last_beat_cycle", 32'(last_hs), 32'(a0 + 5));
    chk("t1_inv_cycle", 32'(inv_cyc), 32'(a0 + 6));

    // Alternating backpressure
    mem_base = 0; ready_mode = 1;
    send(SW'(5), AW'(6));
    wait_idle(100);
    chk("t2_beats", 32'(n_beats), 32'(6));

    // Zero-length frame
    ready_mode = 0;
    send(SW'(7), AW'(0));
    a0 = acc_cyc;
    wait_idle(100);
    chk("t3_inv_cycle", 32'(inv_cyc), 32'(a0 + 1));

    // Single byte held for five stalled cycles
    ready_mode = 3; manual_ready = 1'b0;
    send(SW'(2), AW'(1));
    a0 = acc_cyc;
    for (int i = 0; i < 20 && !bus.tx_valid; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    manual_ready = 1'b1;
    wait_idle(100);
    chk("t4_stall_cycles", 32'(n_stall), 32'(5));
    chk("t4_beat_cycle", 32'(last_hs), 32'(a0 + 7));
    ready_mode = 0;

    // Reset in the middle of a frame, then a normal frame
    send(SW'(4), AW'(8));
    for (int i = 0; i < 50 && n_beats < 3; i++) @(posedge clk);
    #1;
    inv0 = n_inv;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_outputs();
    repeat (5) @(posedge clk);
    #1;
    chk("t5_no_inv_after_reset", 32'(n_inv - inv0), 32'(0));
    send(SW'(6), AW'(2));
    wait_idle(100);

    // Back-to-back requests held valid
    inv0 = n_inv;
    send(SW'(1), AW'(3));
    send(SW'(2), AW'(2));
    chk("t6_b2b_accept_cycle", 32'(acc_cyc), 32'(inv_cyc + 1));
    wait_idle(100);
    chk("t6_inv_pulses", 32'(n_inv - inv0), 32'(2));

    // Longest legal frame at full rate
    mem_mix = 1'b1; mem_base = 'h5a;
    send(SW'(15), AW'(1023));
    a0 = acc_cyc;
    wait_idle(2000);
    chk("max_len_last_beat_cycle", 32'(last_hs), 32'(a0 + 1 + 1023));

    // Randomized frames
    for (int n = 0; n < 40; n++) begin
      mem_base   = int'($urandom_range(0, 255));
      ready_mode = int'($urandom_range(0, 2));
      s = SW'($urandom);
      l = ($urandom_range(0, 4) == 0) ? AW'(0) : AW'($urandom_range(1, 24));
      lim = ready_mode;
      send(s, l);
      a0 = acc_cyc;
      wait_idle(400);
      if (lim == 0 && l != 0) chk("rand_full_rate", 32'(last_hs), 32'(a0 + 1 + int'(l)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
